eth_l2_parser_qinq: RTL and testbench

//  Next-generation L2 parser for AXI4-Stream Ethernet frames. Any DATA_WIDTH; byte-accurate via tkeep.

---
 rtl/eth_parser_pkg.sv | 46 ++++
 rtl/axis_skid_buffer.sv | 61 ++++++
 rtl/eth_l2_parser_qinq.sv | 161 ++++++++++++++++
 tb/tb_eth_l2_parser_qinq.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_parser_pkg.sv
// Shared constants, metadata record layout and decode helpers for the L2 parser.
package eth_parser_pkg;

  localparam logic [15:0] TPID_8100  = 16'h8100;
  localparam logic [15:0] TPID_88A8  = 16'h88A8;
  localparam logic [15:0] TPID_9100  = 16'h9100;
  localparam logic [15:0] ETYPE_IPV4 = 16'h0800;
  localparam logic [15:0] ETYPE_IPV6 = 16'h86DD;
  localparam logic [15:0] ETYPE_ARP  = 16'h0806;

  // proto is one-hot {unknown, arp, ipv6, ipv4}
  localparam logic [3:0] PROTO_IPV4    = 4'b0001;
  localparam logic [3:0] PROTO_IPV6    = 4'b0010;
  localparam logic [3:0] PROTO_ARP     = 4'b0100;
  localparam logic [3:0] PROTO_UNKNOWN = 4'b1000;

  typedef enum logic {S_HDR, S_PAY} parse_state_t;

  typedef struct packed {
    logic [47:0] dest_mac;
    logic [47:0] src_mac;
    logic [1:0]  vlan_count;
    logic [11:0] outer_vid;
    logic [11:0] inner_vid;
    logic [15:0] ethertype;
    logic [4:0]  l2_hdr_len;
    logic [15:0] frame_len;
    logic [3:0]  proto;
    logic        runt;
    logic        tag_overflow;
  } eth_meta_v2_t;

  function automatic logic is_tpid(input logic [15:0] t);
    return (t == TPID_8100) || (t == TPID_88A8) || (t == TPID_9100);
  endfunction

  function automatic logic [3:0] etype_proto(input logic [15:0] t);
    case (t)
      ETYPE_IPV4: return PROTO_IPV4;
      ETYPE_IPV6: return PROTO_IPV6;
      ETYPE_ARP:  return PROTO_ARP;
      default:    return PROTO_UNKNOWN;
    endcase
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI4-Stream skid buffer: one cycle latency, full throughput, registered ready.
module axis_skid_buffer #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   s_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_tkeep,
  input  logic                    s_tvalid,
  input  logic                    s_tlast,
  output logic                    s_tready,
  output logic [DATA_WIDTH-1:0]   m_tdata,
  output logic [DATA_WIDTH/8-1:0] m_tkeep,
  output logic                    m_tvalid,
  output logic                    m_tlast,
  input  logic                    m_tready
);

  localparam int W = DATA_WIDTH + DATA_WIDTH / 8 + 1;

  logic [W-1:0] in_beat, out_beat, skid_beat;
  logic         out_valid, skid_valid, rdy_en;
  logic         accept;

  assign in_beat  = {s_tlast, s_tkeep, s_tdata};
  // rdy_en holds ready low until the first edge after reset is released
  assign s_tready = rdy_en && !skid_valid;
  assign accept   = s_tvalid && s_tready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_en     <= 1'b0;
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      out_beat   <= '0;
      skid_beat  <= '0;
    end else begin
      rdy_en <= 1'b1;
      if (skid_valid) begin
        if (m_tready) begin
          out_beat   <= skid_beat;
          skid_valid <= 1'b0;
        end
      end else if (accept) begin
        if (!out_valid || m_tready) begin
          out_beat  <= in_beat;
          out_valid <= 1'b1;
        end else begin
          skid_beat  <= in_beat;
          skid_valid <= 1'b1;
        end
      end else if (m_tready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign {m_tlast, m_tkeep, m_tdata} = out_beat;
  assign m_tvalid = out_valid;

endmodule

// File: rtl/eth_l2_parser_qinq.sv
// L2 parser: forwards AXI4-Stream frames unmodified and emits one metadata record per frame
// (MACs, up to MAX_VLAN_TAGS stacked tags, ethertype, length, runt/overflow) through a small FIFO.
module eth_l2_parser_qinq
  import eth_parser_pkg::*;
#(
  parameter int DATA_WIDTH    = 64,
  parameter int MAX_VLAN_TAGS = 2,
  parameter int META_DEPTH    = 4,
  parameter int LEN_WIDTH     = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [DATA_WIDTH-1:0]             s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0]           s_axis_tkeep,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  input  logic                              s_axis_tlast,
  output logic [DATA_WIDTH-1:0]             m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]           m_axis_tkeep,
  output logic                              m_axis_tvalid,
  output logic                              m_axis_tlast,
  input  logic                              m_axis_tready,
  output logic [$bits(eth_meta_v2_t)-1:0]   m_meta_tdata,
  output logic                              m_meta_tvalid,
  input  logic                              m_meta_tready,
  output logic [$clog2(META_DEPTH):0]       meta_count
);

  localparam int KW      = DATA_WIDTH / 8;
  localparam int HDR_MAX = 14 + 4 * MAX_VLAN_TAGS;
  localparam int AW      = $clog2(META_DEPTH);
  localparam int PW      = $clog2(KW) + 1;

  logic                 skid_ready, meta_full, accept, push, pop;
  parse_state_t         state;
  logic [LEN_WIDTH-1:0] offset, len_next;
  logic [LEN_WIDTH:0]   len_sum;
  logic [PW-1:0]        beat_bytes;
  logic [7:0]           cap [HDR_MAX];
  logic [7:0]           hdr [HDR_MAX];
  eth_meta_v2_t         rec;
  eth_meta_v2_t         mem [META_DEPTH];
  logic [AW:0]          wr_ptr, rd_ptr;

  // only the tlast beat is held back by a full FIFO; earlier beats keep flowing
  assign s_axis_tready = skid_ready && !(meta_full && s_axis_tlast);
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign push          = accept && s_axis_tlast;

  axis_skid_buffer #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
    .clk      (clk),
    .rst      (rst),
    .s_tdata  (s_axis_tdata),
    .s_tkeep  (s_axis_tkeep),
    .s_tvalid (s_axis_tvalid && !(meta_full && s_axis_tlast)),
    .s_tlast  (s_axis_tlast),
    .s_tready (skid_ready),
    .m_tdata  (m_axis_tdata),
    .m_tkeep  (m_axis_tkeep),
    .m_tvalid (m_axis_tvalid),
    .m_tlast  (m_axis_tlast),
    .m_tready (m_axis_tready)
  );

  always_comb begin
    beat_bytes = '0;
    for (int l = 0; l < KW; l++) beat_bytes = beat_bytes + PW'(s_axis_tkeep[l]);
  end

  assign len_sum  = {1'b0, offset} + (LEN_WIDTH + 1)'(beat_bytes);
  assign len_next = len_sum[LEN_WIDTH] ? '1 : len_sum[LEN_WIDTH-1:0];

  // header view = captured bytes overlaid with the current beat, so the final beat counts too
  always_comb begin
    for (int i = 0; i < HDR_MAX; i++) begin
      hdr[i] = cap[i];
      for (int l = 0; l < KW; l++)
        if (state == S_HDR && s_axis_tkeep[l] && (int'(offset) + l == i))
          hdr[i] = s_axis_tdata[8*l +: 8];
    end
  end

  always_comb begin
    logic [15:0] etype;
    logic [1:0]  vcount;
    logic [11:0] vid0, vid1;
    logic        stop, ovf, runt;
    logic [4:0]  hlen;
    etype  = {hdr[12], hdr[13]};
    vcount = '0;
    vid0   = '0;
    vid1   = '0;
    stop   = 1'b0;
    for (int k = 0; k < MAX_VLAN_TAGS; k++) begin
      if (!stop && is_tpid(etype)) begin
        if (k == 0) vid0 = {hdr[14+4*k][3:0], hdr[15+4*k]};
        else        vid1 = {hdr[14+4*k][3:0], hdr[15+4*k]};
        etype  = {hdr[16+4*k], hdr[17+4*k]};
        vcount = vcount + 2'd1;
      end else begin
        stop = 1'b1;
      end
    end
    ovf  = !stop && is_tpid(etype);
    hlen = 5'd14 + {1'b0, vcount, 2'b00};
    runt = len_next < LEN_WIDTH'(hlen);

    rec.dest_mac     = {hdr[0], hdr[1], hdr[2], hdr[3], hdr[4], hdr[5]};
    rec.src_mac      = {hdr[6], hdr[7], hdr[8], hdr[9], hdr[10], hdr[11]};
    rec.vlan_count   = vcount;
    rec.outer_vid    = vid0;
    rec.inner_vid    = vid1;
    rec.ethertype    = etype;
    rec.l2_hdr_len   = hlen;
    rec.frame_len    = 16'(len_next);
    rec.proto        = (runt || ovf) ? PROTO_UNKNOWN : etype_proto(etype);
    rec.runt         = runt;
    rec.tag_overflow = ovf;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_HDR;
      offset <= '0;
      for (int i = 0; i < HDR_MAX; i++) cap[i] <= '0;
    end else if (accept) begin
      if (s_axis_tlast) begin
        state  <= S_HDR;
        offset <= '0;
        for (int i = 0; i < HDR_MAX; i++) cap[i] <= '0;
      end else begin
        offset <= len_next;
        if (state == S_HDR) begin
          for (int i = 0; i < HDR_MAX; i++) cap[i] <= hdr[i];
          if (len_next >= LEN_WIDTH'(HDR_MAX)) state <= S_PAY;
        end
      end
    end
  end

  assign meta_count    = wr_ptr - rd_ptr;
  assign meta_full     = meta_count == (AW + 1)'(META_DEPTH);
  assign m_meta_tvalid = wr_ptr != rd_ptr;
  assign pop           = m_meta_tvalid && m_meta_tready;
  assign m_meta_tdata  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < META_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= rec;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: tb/tb_eth_l2_parser_qinq.sv
// Bench for eth_l2_parser_qinq: directed frame table, FIFO back-pressure, mid-frame reset, random stalls.
module tb_eth_l2_parser_qinq;
  import eth_parser_pkg::*;

  localparam int DW = 64;
  localparam int KW = DW / 8;
  localparam int NV = 12;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [DW-1:0]   s_axis_tdata = '0;
  logic [KW-1:0]   s_axis_tkeep = '0;
  logic            s_axis_tvalid = 1'b0;
  logic            s_axis_tready;
  logic            s_axis_tlast = 1'b0;
  logic [DW-1:0]   m_axis_tdata;
  logic [KW-1:0]   m_axis_tkeep;
  logic            m_axis_tvalid;
  logic            m_axis_tlast;
  logic            m_axis_tready = 1'b1;
  logic [$bits(eth_meta_v2_t)-1:0] m_meta_tdata;
  logic            m_meta_tvalid;
  logic            m_meta_tready = 1'b1;
  logic [2:0]      meta_count;

  eth_l2_parser_qinq dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .m_meta_tdata(m_meta_tdata), .m_meta_tvalid(m_meta_tvalid), .m_meta_tready(m_meta_tready),
    .meta_count(meta_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           len;
    int           ntag;
    logic [15:0]  tpid [3];
    logic [11:0]  vid [3];
    logic [15:0]  etype;
    bit           empty_tail;
    logic [1:0]   exp_vc;
    logic [11:0]  exp_outer, exp_inner;
    logic [15:0]  exp_etype;
    logic [4:0]   exp_hlen;
    logic [3:0]   exp_proto;
    logic         exp_runt, exp_ovf;
    int           src_bytes;
  } vec_t;

  vec_t              vt [NV];
  vec_t              fifo_v;
  logic [DW+KW:0]    exp_beats [$];
  eth_meta_v2_t      exp_meta [$];
  int                checks = 0;
  int                failures = 0;
  bit                rand_en = 1'b0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int len, input int ntag,
      input logic [15:0] tp0, input logic [11:0] v0, input logic [15:0] tp1, input logic [11:0] v1,
      input logic [15:0] tp2, input logic [11:0] v2, input logic [15:0] et, input bit tail,
      input logic [1:0] vc, input logic [11:0] o, input logic [11:0] inr, input logic [15:0] eet,
      input logic [4:0] h, input logic [3:0] p, input logic r, input logic ov, input int srcb);
    vec_t v;
    v.len = len; v.ntag = ntag; v.etype = et; v.empty_tail = tail;
    v.tpid[0] = tp0; v.tpid[1] = tp1; v.tpid[2] = tp2;
    v.vid[0] = v0;   v.vid[1] = v1;   v.vid[2] = v2;
    v.exp_vc = vc; v.exp_outer = o; v.exp_inner = inr; v.exp_etype = eet;
    v.exp_hlen = h; v.exp_proto = p; v.exp_runt = r; v.exp_ovf = ov; v.src_bytes = srcb;
    return v;
  endfunction

  function automatic eth_meta_v2_t exp_rec(input vec_t v, input int id);
    eth_meta_v2_t r;
    logic [47:0]  s;
    s = {40'h0ABBCCDDEE, 8'(id)};
    for (int b = v.src_bytes; b < 6; b++) s[8*(5-b) +: 8] = 8'h00;
    r.dest_mac     = {40'h0211223344, 8'(id)};
    r.src_mac      = s;
    r.vlan_count   = v.exp_vc;
    r.outer_vid    = v.exp_outer;
    r.inner_vid    = v.exp_inner;
    r.ethertype    = v.exp_etype;
    r.l2_hdr_len   = v.exp_hlen;
    r.frame_len    = 16'(v.len);
    r.proto        = v.exp_proto;
    r.runt         = v.exp_runt;
    r.tag_overflow = v.exp_ovf;
    return r;
  endfunction

  function automatic logic [DW-1:0] keep_mask(input logic [KW-1:0] k);
    logic [DW-1:0] m;
    for (int l = 0; l < KW; l++) m[8*l +: 8] = {8{k[l]}};
    return m;
  endfunction

  // called at posedge+1; returns at posedge+1 after the beat is taken
  task automatic drive_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l);
    int t;
    t = 0;
    s_axis_tdata = d; s_axis_tkeep = k; s_axis_tlast = l; s_axis_tvalid = 1'b1;
    exp_beats.push_back({l, k, d});
    forever begin
      @(negedge clk);
      if (s_axis_tready) break;
      t++;
      if (t > 2000) begin
        chk("accept_timeout", 1'b0, 1'b1);
        break;
      end
    end
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0;
  endtask

  // nbeats > 0 sends only that many beats (no tlast, no record expected)
  task automatic send_frame(input vec_t v, input int id, input int gap, input int nbeats);
    logic [7:0]    fb [$];
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    int            bi;
    fb = {8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'(id), 8'h0A, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'(id)};
    for (int t = 0; t < v.ntag; t++) begin
      fb.push_back(v.tpid[t][15:8]);
      fb.push_back(v.tpid[t][7:0]);
      fb.push_back(8'hA0 | {4'h0, v.vid[t][11:8]});
      fb.push_back(v.vid[t][7:0]);
    end
    fb.push_back(v.etype[15:8]);
    fb.push_back(v.etype[7:0]);
    while (fb.size() < v.len) fb.push_back(8'(fb.size() * 7 + id));
    while (fb.size() > v.len) void'(fb.pop_back());
    if (nbeats == 0) exp_meta.push_back(exp_rec(v, id));
    bi = 0;
    for (int off = 0; off < v.len; off += KW) begin
      d = '0; k = '0;
      for (int l = 0; l < KW; l++)
        if (off + l < v.len) begin
          d[8*l +: 8] = fb[off+l];
          k[l] = 1'b1;
        end
      drive_beat(d, k, (nbeats == 0) && (off + KW >= v.len) && !v.empty_tail);
      bi++;
      if (nbeats != 0 && bi >= nbeats) return;
      repeat ($urandom_range(0, gap)) begin @(posedge clk); #1; end
    end
    if (v.empty_tail) drive_beat('0, '0, 1'b1);
  endtask

  task automatic drain(input string nm);
    int t;
    t = 0;
    while ((exp_beats.size() != 0 || exp_meta.size() != 0) && t < 1000) begin
      @(posedge clk);
      t++;
    end
    @(posedge clk); #1;
    chk({nm, "_beats_left"}, exp_beats.size(), 0);
    chk({nm, "_meta_left"}, exp_meta.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!rst && m_axis_tvalid && m_axis_tready) begin
      if (exp_beats.size() == 0) begin
        checks++; failures++;
        $display("FAIL data_extra: got beat %0h expected none", m_axis_tdata);
      end else
        chk("data_beat", {m_axis_tlast, m_axis_tkeep, m_axis_tdata & keep_mask(m_axis_tkeep)},
            exp_beats.pop_front());
    end
    if (!rst && m_meta_tvalid && m_meta_tready) begin
      if (exp_meta.size() == 0) begin
        checks++; failures++;
        $display("FAIL meta_extra: got record %0h expected none", m_meta_tdata);
      end else
        chk("meta_record", m_meta_tdata, exp_meta.pop_front());
    end
  end

  always @(posedge clk) begin
    if (rand_en) begin
      #1;
      m_axis_tready = 1'($urandom_range(0, 1));
      m_meta_tready = $urandom_range(0, 3) != 0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = mk(64, 0, 0, 0, 0, 0, 0, 0, 16'h0800, 0, 0, 0, 0, 16'h0800, 14, 4'b0001, 0, 0, 6);
    vt[1]  = mk(100, 2, 16'h88A8, 12'h123, 16'h8100, 12'h456, 0, 0, 16'h86DD, 0,
                2, 12'h123, 12'h456, 16'h86DD, 22, 4'b0010, 0, 0, 6);
    vt[2]  = mk(80, 3, 16'h88A8, 12'h010, 16'h8100, 12'h020, 16'h8100, 12'h030, 16'h0800, 0,
                2, 12'h010, 12'h020, 16'h8100, 22, 4'b1000, 0, 1, 6);
    vt[3]  = mk(60, 1, 16'h9100, 12'hABC, 0, 0, 0, 0, 16'h0806, 0,
                1, 12'hABC, 0, 16'h0806, 18, 4'b0100, 0, 0, 6);
    vt[4]  = mk(61, 0, 0, 0, 0, 0, 0, 0, 16'h88CC, 0, 0, 0, 0, 16'h88CC, 14, 4'b1000, 0, 0, 6);
    vt[5]  = mk(10, 0, 0, 0, 0, 0, 0, 0, 16'h0800, 0, 0, 0, 0, 16'h0000, 14, 4'b1000, 1, 0, 4);
    vt[6]  = mk(16, 1, 16'h8100, 12'h055, 0, 0, 0, 0, 16'h0800, 0,
                1, 12'h055, 0, 16'h0000, 18, 4'b1000, 1, 0, 6);
    vt[7]  = mk(14, 0, 0, 0, 0, 0, 0, 0, 16'h0800, 0, 0, 0, 0, 16'h0800, 14, 4'b0001, 0, 0, 6);
    vt[8]  = mk(8, 0, 0, 0, 0, 0, 0, 0, 16'h0800, 0, 0, 0, 0, 16'h0000, 14, 4'b1000, 1, 0, 2);
    vt[9]  = mk(64, 0, 0, 0, 0, 0, 0, 0, 16'h86DD, 1, 0, 0, 0, 16'h86DD, 14, 4'b0010, 0, 0, 6);
    vt[10] = mk(18, 1, 16'h8100, 12'h7FF, 0, 0, 0, 0, 16'h0800, 0,
                1, 12'h7FF, 0, 16'h0800, 18, 4'b0001, 0, 0, 6);
    vt[11] = mk(72, 2, 16'h8100, 12'h001, 16'h9100, 12'hFFE, 0, 0, 16'h0806, 0,
                2, 12'h001, 12'hFFE, 16'h0806, 22, 4'b0100, 0, 0, 6);
    fifo_v = mk(24, 0, 0, 0, 0, 0, 0, 0, 16'h0800, 0, 0, 0, 0, 16'h0800, 14, 4'b0001, 0, 0, 6);

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tdata, m_axis_tkeep,
                          m_meta_tvalid, m_meta_tdata, meta_count}, '0);
    rst = 1'b0;
    #1;
    chk("ready_before_edge", s_axis_tready, 1'b0);
    @(negedge clk);
    chk("ready_after_edge", s_axis_tready, 1'b1);
    chk("reset_meta_count", meta_count, 3'd0);
    @(posedge clk); #1;

    // directed table
    for (int i = 0; i < NV; i++) send_frame(vt[i], i, 0, 0);
    drain("table");

    // FIFO full: four records held, fifth tlast stalls, data path still drains
    m_meta_tready = 1'b0;
    fork
      for (int f = 0; f < 6; f++) send_frame(fifo_v, 20 + f, 0, 0);
    join_none
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("fifo_count_full", meta_count, 3'd4);
    chk("fifo_meta_valid", m_meta_tvalid, 1'b1);
    chk("fifo_tlast_stall", {s_axis_tvalid, s_axis_tlast, s_axis_tready}, 3'b110);
    chk("fifo_data_drained", {m_axis_tvalid, 32'(exp_beats.size())}, {1'b0, 32'd1});
    @(posedge clk); #1;
    m_meta_tready = 1'b1;
    wait fork;
    drain("fifo");
    chk("fifo_count_empty", meta_count, 3'd0);

    // reset in the middle of a frame
    send_frame(vt[1], 1, 0, 2);
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("midrst_outputs", {s_axis_tready, m_axis_tvalid, m_meta_tvalid, meta_count}, '0);
    rst = 1'b0;
    exp_beats.delete();
    @(posedge clk); #1;
    send_frame(vt[0], 50, 0, 0);
    drain("midrst");

    // random back-pressure and gaps
    rand_en = 1'b1;
    for (int n = 0; n < 40; n++) send_frame(vt[$urandom_range(0, NV-1)], 100 + n, 2, 0);
    rand_en = 1'b0;
    @(posedge clk); #2;
    m_axis_tready = 1'b1;
    m_meta_tready = 1'b1;
    drain("random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
